// File: rtl/mux_scan_n.sv
// N-channel, W-bit registered multiplexer with manual select and auto-scan
// round-robin mode (programmable dwell per channel, wrap pulse at channel 0).
module mux_scan_n #(
    parameter int N     = 4,
    parameter int W     = 1,
    parameter int DWELL = 4,
    localparam int SW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] d,
    input  logic [SW-1:0]  sel,
    input  logic           mode,
    input  logic           en,
    output logic [W-1:0]   y,
    output logic [SW-1:0]  ch,
    output logic           valid,
    output logic           wrap
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic {MANUAL, SCAN} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    y_q, y_d;
    logic [SW-1:0]   ch_q, ch_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            valid_q, valid_d;
    logic            wrap_q, wrap_d;

    logic            adv;
    logic            last_ch;
    logic [SW-1:0]   ch_nxt;

    function automatic logic [W-1:0] pick(input logic [N*W-1:0] data,
                                          input logic [SW-1:0]  idx);
        logic [W-1:0] r;
        r = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (idx == SW'(k)) r = data[k*W +: W];
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MANUAL;
            y_q     <= '0;
            ch_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        adv     = (cnt_q == CW'(DWELL - 1));
        last_ch = (ch_q == SW'(N - 1));
        ch_nxt  = adv ? (last_ch ? '0 : ch_q + SW'(1)) : ch_q;

        if (en) begin
            if (!mode) begin
                state_d = MANUAL;
                cnt_d   = '0;
                if (int'(sel) < N) begin
                    y_d     = pick(d, sel);
                    ch_d    = sel;
                    valid_d = 1'b1;
                end else begin
                    y_d = '0;
                end
            end else if (state_q == MANUAL) begin
                // Entry edge is the first dwell cycle of the current channel.
                state_d = SCAN;
                y_d     = pick(d, ch_q);
                valid_d = 1'b1;
                cnt_d   = (DWELL == 1) ? '0 : CW'(1);
            end else begin
                y_d     = pick(d, ch_nxt);
                ch_d    = ch_nxt;
                cnt_d   = adv ? '0 : cnt_q + CW'(1);
                valid_d = 1'b1;
                wrap_d  = adv && last_ch;
            end
        end
    end

    assign y     = y_q;
    assign ch    = ch_q;
    assign valid = valid_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// Directed self-checking bench for mux_scan_n: a 4-channel DWELL=3 instance
// and a 5-channel DWELL=1 instance for out-of-range select and fast wrap.
module tb_mux_scan_n;

    localparam logic [31:0] D   = 32'hD4C3B2A1;
    localparam logic [31:0] D55 = 32'hD4C355A1;
    localparam logic [39:0] D5  = 40'hE5D4C3B2A1;

    logic        clk = 1'b0;
    logic        rst, en, mode;
    logic [1:0]  sel;
    logic [31:0] d;
    logic [7:0]  y;
    logic [1:0]  ch;
    logic        valid, wrap;

    logic        rst5, en5, mode5;
    logic [2:0]  sel5;
    logic [39:0] d5;
    logic [7:0]  y5;
    logic [2:0]  ch5;
    logic        valid5, wrap5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_scan_n #(.N(4), .W(8), .DWELL(3)) dut (
        .clk(clk), .rst(rst), .d(d), .sel(sel), .mode(mode), .en(en),
        .y(y), .ch(ch), .valid(valid), .wrap(wrap)
    );

    mux_scan_n #(.N(5), .W(8), .DWELL(1)) dut5 (
        .clk(clk), .rst(rst5), .d(d5), .sel(sel5), .mode(mode5), .en(en5),
        .y(y5), .ch(ch5), .valid(valid5), .wrap(wrap5)
    );

    typedef struct {
        logic        rst, en, mode;
        logic [1:0]  sel;
        logic [31:0] d;
        logic [7:0]  y;
        logic [1:0]  ch;
        logic        valid, wrap;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(logic r, logic e, logic m, logic [1:0] s,
                                logic [31:0] dd, logic [7:0] ey,
                                logic [1:0] ec, logic ev, logic ew);
        vec_t v;
        v.rst = r; v.en = e; v.mode = m; v.sel = s; v.d = dd;
        v.y = ey; v.ch = ec; v.valid = ev; v.wrap = ew;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step_chk(input string name, input logic [7:0] ey,
                            input logic [1:0] ec, input logic ev, input logic ew);
        @(posedge clk); #1;
        check({name, ".y"}, 32'(y), 32'(ey));
        check({name, ".ch"}, 32'(ch), 32'(ec));
        check({name, ".valid"}, 32'(valid), 32'(ev));
        check({name, ".wrap"}, 32'(wrap), 32'(ew));
    endtask

    task automatic step5(input string name, input logic [7:0] ey,
                         input logic [2:0] ec, input logic ev, input logic ew);
        @(posedge clk); #1;
        check({name, ".y"}, 32'(y5), 32'(ey));
        check({name, ".ch"}, 32'(ch5), 32'(ec));
        check({name, ".valid"}, 32'(valid5), 32'(ev));
        check({name, ".wrap"}, 32'(wrap5), 32'(ew));
    endtask

    initial begin
        vecs[0]  = mk(1, 0, 0, 0, D,   8'h00, 0, 0, 0);
        vecs[1]  = mk(1, 1, 0, 3, D,   8'h00, 0, 0, 0);
        vecs[2]  = mk(0, 1, 0, 0, D,   8'hA1, 0, 1, 0);
        vecs[3]  = mk(0, 1, 0, 1, D,   8'hB2, 1, 1, 0);
        vecs[4]  = mk(0, 1, 0, 2, D,   8'hC3, 2, 1, 0);
        vecs[5]  = mk(0, 1, 0, 3, D,   8'hD4, 3, 1, 0);
        vecs[6]  = mk(1, 1, 1, 0, D,   8'h00, 0, 0, 0);
        vecs[7]  = mk(0, 1, 1, 3, D,   8'hA1, 0, 1, 0);
        vecs[8]  = mk(0, 1, 1, 3, D,   8'hA1, 0, 1, 0);
        vecs[9]  = mk(0, 1, 1, 3, D,   8'hB2, 1, 1, 0);
        vecs[10] = mk(0, 1, 1, 3, D55, 8'h55, 1, 1, 0);
        vecs[11] = mk(0, 1, 1, 3, D55, 8'h55, 1, 1, 0);
        vecs[12] = mk(0, 1, 1, 3, D,   8'hC3, 2, 1, 0);
        vecs[13] = mk(0, 1, 1, 3, D,   8'hC3, 2, 1, 0);
        vecs[14] = mk(0, 1, 1, 3, D,   8'hC3, 2, 1, 0);
        vecs[15] = mk(0, 1, 1, 3, D,   8'hD4, 3, 1, 0);
        vecs[16] = mk(0, 1, 1, 3, D,   8'hD4, 3, 1, 0);
        vecs[17] = mk(0, 1, 1, 3, D,   8'hD4, 3, 1, 0);
        vecs[18] = mk(0, 1, 1, 3, D,   8'hA1, 0, 1, 1);
        vecs[19] = mk(0, 1, 1, 3, D,   8'hA1, 0, 1, 0);

        rst5 = 1'b1; en5 = 1'b0; mode5 = 1'b0; sel5 = '0; d5 = D5;
        rst = 1'b1; en = 1'b0; mode = 1'b0; sel = '0; d = D;

        for (int i = 0; i < 20; i++) begin
            rst = vecs[i].rst; en = vecs[i].en; mode = vecs[i].mode;
            sel = vecs[i].sel; d = vecs[i].d;
            step_chk($sformatf("vec%0d", i), vecs[i].y, vecs[i].ch,
                     vecs[i].valid, vecs[i].wrap);
        end

        // Finish ch0 dwell, run ch1, reach second cycle of ch2.
        step_chk("pre_frz0", 8'hA1, 0, 1, 0);
        step_chk("pre_frz1", 8'hB2, 1, 1, 0);
        step_chk("pre_frz2", 8'hB2, 1, 1, 0);
        step_chk("pre_frz3", 8'hB2, 1, 1, 0);
        step_chk("pre_frz4", 8'hC3, 2, 1, 0);
        step_chk("pre_frz5", 8'hC3, 2, 1, 0);
        en = 1'b0; d = 32'h11223344;
        for (int i = 0; i < 5; i++) step_chk($sformatf("frz%0d", i), 8'hC3, 2, 0, 0);
        en = 1'b1; d = D;
        step_chk("post_frz0", 8'hC3, 2, 1, 0);
        step_chk("post_frz1", 8'hD4, 3, 1, 0);
        step_chk("post_frz2", 8'hD4, 3, 1, 0);

        // ch3 with cnt=1: reset while disabled, then re-enter scan.
        en = 1'b0; rst = 1'b1;
        step_chk("rst_mid", 8'h00, 0, 0, 0);
        rst = 1'b0; en = 1'b1;
        step_chk("reentry0", 8'hA1, 0, 1, 0);
        step_chk("reentry1", 8'hA1, 0, 1, 0);
        step_chk("reentry2", 8'hB2, 1, 1, 0);
        step_chk("reentry3", 8'hB2, 1, 1, 0);
        step_chk("reentry4", 8'hB2, 1, 1, 0);
        step_chk("reentry5", 8'hC3, 2, 1, 0);

        mode = 1'b0; sel = 2'd1;
        step_chk("msw_man", 8'hB2, 1, 1, 0);
        mode = 1'b1; sel = 2'd3;
        step_chk("msw_scan0", 8'hB2, 1, 1, 0);
        step_chk("msw_scan1", 8'hB2, 1, 1, 0);
        step_chk("msw_scan2", 8'hC3, 2, 1, 0);

        // Five-channel instance, held in reset until now.
        step5("n5_rst", 8'h00, 0, 0, 0);
        rst5 = 1'b0; en5 = 1'b1; sel5 = 3'd2;
        step5("n5_sel2", 8'hC3, 2, 1, 0);
        sel5 = 3'd6;
        step5("n5_sel6", 8'h00, 2, 0, 0);
        sel5 = 3'd4;
        step5("n5_sel4", 8'hE5, 4, 1, 0);
        sel5 = 3'd5;
        step5("n5_sel5", 8'h00, 4, 0, 0);
        sel5 = 3'd7;
        step5("n5_sel7", 8'h00, 4, 0, 0);
        mode5 = 1'b1;
        step5("n5_entry", 8'hE5, 4, 1, 0);
        step5("n5_wrap", 8'hA1, 0, 1, 1);
        step5("n5_adv", 8'hB2, 1, 1, 0);
        en5 = 1'b0;
        step5("n5_hold", 8'hB2, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_scan_n.md
# mux_scan_n

Parametrised N-channel, W-bit multiplexer with a registered output and two selection modes: manual (external select) and auto-scan (hardware round-robin with a programmable dwell per channel). It replaces the fixed combinational 4:1, 1-bit mux wherever a monitored bus must be sampled channel by channel. Typical uses are time-division readout and display multiplexing, with a scan-complete pulse for downstream framing.

## Interface
- N, 4, number of input channels (N >= 2)
- W, 1, data width per channel (W >= 1)
- DWELL, 4, enabled cycles each channel is held in scan mode (DWELL >= 1)
- SW (localparam) = max(1, clog2(N)), select/channel index width
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- d  input  N*W  packed channel data; channel k at bits [k*W +: W]
- sel  input  SW  manual channel select (mode = 0)
- mode  input  1  0 = manual, 1 = auto-scan
- en  input  1  advance/sample enable; 0 freezes all state
- y  output  W  registered selected data
- ch  output  SW  index of channel currently on y
- valid  output  1  y was sampled at the last edge from a legal channel
- wrap  output  1  one-cycle pulse: scan returned from channel N-1 to 0

## Operation
- Clocking and reset: one clock; reset is synchronous and active-high. rst = 1 at an edge overrides all other inputs, including en = 0.
- Reset values: y = 0, ch = 0, valid = 0, wrap = 0, dwell counter cnt = 0, state = MANUAL.
- FSM states MANUAL and SCAN. At an enabled edge, mode = 1 selects SCAN; mode = 0 selects MANUAL. With en = 0 the state is held.
- en = 0 at an edge: y, ch, cnt and state hold; valid <= 0, wrap <= 0.
- MANUAL, enabled edge:
  - sel < N: y <= d[sel], ch <= sel, valid <= 1.
  - sel >= N (only possible when N is not a power of 2): y <= 0, ch holds, valid <= 0.
  - In both cases wrap <= 0 and cnt <= 0.
- Entry edge into SCAN (state MANUAL, mode = 1, en = 1):
  - Scanning starts from the current ch: y <= d[ch], valid <= 1, wrap <= 0.
  - cnt <= (DWELL == 1) ? 0 : 1, so the entry edge counts as the first dwell cycle.
- SCAN, enabled edge:
  - adv = (cnt == DWELL-1).
  - ch_nxt = adv ? (ch == N-1 ? 0 : ch+1) : ch.
  - y <= d[ch_nxt], ch <= ch_nxt, cnt <= adv ? 0 : cnt+1, valid <= 1.
  - wrap <= adv && (ch == N-1).
  - y tracks live data of the held channel on every enabled cycle, not a single snapshot.
- SCAN to MANUAL (mode = 0 at an enabled edge): the MANUAL rules apply on that same edge, and cnt <= 0.
- Each channel occupies exactly DWELL consecutive enabled cycles on y, including the first channel after entry. Disabled cycles do not count toward the dwell.
- Width rules:
  - cnt width = max(1, clog2(DWELL)).
  - ch wraps at N, not at 2^SW. In scan mode ch never takes a value >= N.

## Timing
- Latency is 1 cycle: d and sel sampled at edge t appear on y, ch and valid after edge t.
- No combinational path from any input to any output.
- wrap is high for exactly one cycle: the first cycle in which y shows channel 0 after channel N-1.
- mode, sel and en are sampled only at edges and have no setup relation to each other beyond the standard clock setup.

## Test plan
- Reset / manual sweep (N=4, W=8, d = {8'hD4, 8'hC3, 8'hB2, 8'hA1}): hold rst for 2 cycles -> y = 0, ch = 0, valid = 0. Then sel = 0, 1, 2, 3 with en = 1 -> y = A1, B2, C3, D4 one cycle after each sel; ch follows sel; valid = 1.
- Out-of-range select (N=5): sel = 6 -> next cycle y = 0, valid = 0, ch keeps its previous value. Then sel = 4 -> y = d[4], valid = 1.
- Scan dwell (N=4, DWELL=3): from reset, set mode = 1 with en held at 1 -> ch sequence 0,0,0,1,1,1,2,2,2,3,3,3,0. wrap is high only in the cycle ch returns to 0. Changing d[1] mid-dwell shows the new value on y the following cycle.
- Enable freeze (DWELL=3): deassert en for 5 cycles during the second cycle of ch 2 -> y, ch and cnt hold, valid = 0, wrap = 0. Reasserting en gives exactly one more ch = 2 cycle, then ch = 3.
- Reset mid-scan: assert rst while ch = 3 with cnt = 1 and en = 0 -> after the edge y = 0, ch = 0, state = MANUAL. With mode still 1 and en = 1, the next edge re-enters scan at ch 0 and gives a full DWELL on ch 0.
- Mode switch: in SCAN on ch 2, set mode = 0 with sel = 1 -> next cycle ch = 1, y = d[1]. Set mode = 1 again -> scanning resumes at ch 1 for a full DWELL.
